apb4_mem_slave: RTL and testbench

- Parametrised APB4 memory-mapped slave: byte-addressed word memory with configurable width and depth, byte-lane write strobes, programmable wait states (PREADY) and error response (PSLVERR).
- Sits behind the APB bridge as the generic scratch/register-memory target for bus-protocol verification benches.
- Replaces the fixed 256-entry, zero-wait, no-error slave.

---
 rtl/apb_pkg.sv | 29 ++
 rtl/apb_bytewr_ram.sv | 31 +++
 rtl/apb4_mem_slave.sv | 175 +++++++++++++++++
 tb/tb_apb4_mem_slave.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types, constants and helpers for the APB4 memory slave.
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_slv_state_e;

  // Value parked on prdata whenever no read is completing.
  localparam logic [31:0] APB_IDLE_RDATA = 32'hFEDC_BA98;

  // Byte-lane merge sized for the widest supported bus (64 bits / 8 lanes).
  // Callers zero-extend narrower words and truncate the result.
  function automatic logic [63:0] strb_merge(input logic [63:0] old_word,
                                             input logic [63:0] new_word,
                                             input logic [7:0]  strb);
    logic [63:0] merged;
    merged = old_word;
    for (int k = 0; k < 8; k++) begin
      if (strb[k]) begin
        merged[8*k +: 8] = new_word[8*k +: 8];
      end else begin
        merged[8*k +: 8] = old_word[8*k +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/apb_bytewr_ram.sv
// DEPTH x DATA_WIDTH storage: synchronous byte-enable write, combinational read.
module apb_bytewr_ram
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int IDX_W      = 8
) (
  input  logic                    clk,
  input  logic                    i_we,
  input  logic [IDX_W-1:0]        i_waddr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic [IDX_W-1:0]        i_raddr,
  output logic [DATA_WIDTH-1:0]   o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Read-modify-write of the addressed word, touching only enabled lanes.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= DATA_WIDTH'(strb_merge(64'(r_mem[i_waddr]),
                                               64'(i_wdata),
                                               8'(i_wstrb)));
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/apb4_mem_slave.sv
// APB4 memory slave: address decode, wait-state FSM and registered response.
module apb4_mem_slave
  import apb_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 32,
  parameter int          DATA_WIDTH  = 32,
  parameter int          DEPTH       = 256,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] IDLE_RDATA  = APB_IDLE_RDATA
) (
  input  logic                    pclk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LSB_MASK = ADDR_WIDTH'((64'd1 << LSB) - 64'd1);
  localparam logic [DATA_WIDTH-1:0] IDLE_D   = DATA_WIDTH'(IDLE_RDATA);

  apb_slv_state_e r_state, w_state_nxt;

  logic [3:0]            r_cnt, w_cnt_nxt;
  logic                  r_pready, w_pready_nxt;
  logic                  r_pslverr, w_pslverr_nxt;
  logic [DATA_WIDTH-1:0] r_prdata, w_prdata_nxt;

  logic [IDX_W-1:0]      r_index;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_strb;
  logic                  r_err;

  logic [ADDR_WIDTH-1:0] w_word;
  logic [IDX_W-1:0]      w_index;
  logic                  w_err;
  logic                  w_capture;
  logic                  w_we;
  logic [IDX_W-1:0]      w_raddr;
  logic [DATA_WIDTH-1:0] w_rdata;

  // The full word number is range-checked, so upper address bits never alias.
  assign w_word  = paddr >> LSB;
  assign w_index = w_word[IDX_W-1:0];
  assign w_err   = (|(paddr & LSB_MASK)) || (w_word >= ADDR_WIDTH'(DEPTH));

  // With zero wait states the read happens at the SETUP edge, so use the live index.
  assign w_raddr = (r_state == IDLE) ? w_index : r_index;

  apb_bytewr_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clk     (pclk),
    .i_we    (w_we),
    .i_waddr (r_index),
    .i_wdata (r_wdata),
    .i_wstrb (r_strb),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // Next-state, wait counter and next response values.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pready_nxt  = 1'b0;
    w_pslverr_nxt = 1'b0;
    w_prdata_nxt  = IDLE_D;
    w_capture     = 1'b0;
    w_we          = 1'b0;
    case (r_state)
      IDLE: begin
        if (psel && !penable) begin
          w_capture   = 1'b1;
          w_state_nxt = ACCESS;
          w_cnt_nxt   = 4'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            w_pready_nxt  = 1'b1;
            w_pslverr_nxt = w_err;
            w_prdata_nxt  = (w_err || pwrite) ? IDLE_D : w_rdata;
          end else begin
            w_pready_nxt = 1'b0;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ACCESS: begin
        if (r_pready) begin
          // Completion edge: commit the write, then return to IDLE.
          w_state_nxt = IDLE;
          w_we        = psel && penable && r_write && !r_err;
        end else if (!psel) begin
          // Master abandoned the transfer.
          w_state_nxt = IDLE;
          w_cnt_nxt   = 4'd0;
        end else begin
          if (r_cnt != 4'd0) begin
            w_cnt_nxt = r_cnt - 4'd1;
          end else begin
            w_cnt_nxt = 4'd0;
          end
          if (r_cnt == 4'd1) begin
            w_pready_nxt  = 1'b1;
            w_pslverr_nxt = r_err;
            w_prdata_nxt  = (r_err || r_write) ? IDLE_D : w_rdata;
          end else begin
            w_pready_nxt = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Wait counter and registered response outputs.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_cnt     <= 4'd0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= IDLE_D;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_pready  <= w_pready_nxt;
      r_pslverr <= w_pslverr_nxt;
      r_prdata  <= w_prdata_nxt;
    end
  end

  // Transfer fields held for the ACCESS phase; later bus changes are ignored.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      r_index <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_strb  <= '0;
      r_err   <= 1'b0;
    end else if (w_capture) begin
      r_index <= w_index;
      r_write <= pwrite;
      r_wdata <= pwdata;
      r_strb  <= pstrb;
      r_err   <= w_err;
    end
  end

  assign prdata  = r_prdata;
  assign pready  = r_pready;
  assign pslverr = r_pslverr;

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Directed bench: four slaves with 0/2/3/4 wait states on a shared bus.
module tb_apb4_mem_slave;

  localparam logic [31:0] IDLE = 32'hFEDC_BA98;

  logic        pclk;
  logic        rst;
  logic [31:0] paddr;
  logic [3:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata_a [4];
  logic [3:0]  pready_a;
  logic [3:0]  pslverr_a;

  int n_chk = 0;
  int n_err = 0;

  // Slave 0: 0 waits, slave 1: 2 waits, slave 2: 3 waits, slave 3: 4 waits.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int WS = (g == 0) ? 0 : (g == 1) ? 2 : (g == 2) ? 3 : 4;
    apb4_mem_slave #(.WAIT_STATES(WS)) u_dut (
      .pclk    (pclk),
      .rst     (rst),
      .paddr   (paddr),
      .psel    (psel[g]),
      .penable (penable),
      .pwrite  (pwrite),
      .pwdata  (pwdata),
      .pstrb   (pstrb),
      .prdata  (prdata_a[g]),
      .pready  (pready_a[g]),
      .pslverr (pslverr_a[g])
    );
  end

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask

  // One full transfer starting at #1 after a rising edge; ends at #1 after the completion edge.
  task automatic xfer(input int d, input int ws, input logic [31:0] addr, input logic wr,
                      input logic [31:0] wd, input logic [3:0] st,
                      input logic exp_err, input logic [31:0] exp_rd, input string tag);
    psel    = 4'b0000;
    psel[d] = 1'b1;
    penable = 1'b0;
    paddr   = addr;
    pwrite  = wr;
    pwdata  = wd;
    pstrb   = st;
    @(negedge pclk);
    chk({tag, "/setup_rdy"}, {31'd0, pready_a[d]}, 32'd0);
    chk({tag, "/setup_rd"}, prdata_a[d], IDLE);
    cyc();
    penable = 1'b1;
    for (int k = 0; k <= ws; k++) begin
      @(negedge pclk);
      if (k < ws) begin
        chk({tag, "/wait_rdy"}, {31'd0, pready_a[d]}, 32'd0);
      end else begin
        chk({tag, "/rdy"}, {31'd0, pready_a[d]}, 32'd1);
        chk({tag, "/err"}, {31'd0, pslverr_a[d]}, {31'd0, exp_err});
        chk({tag, "/rd"}, prdata_a[d], exp_rd);
      end
      cyc();
    end
    psel    = 4'b0000;
    penable = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    psel    = 4'b0000;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 32'd0;
    pwdata  = 32'd0;
    pstrb   = 4'd0;

    // Reset values on every instance.
    @(negedge pclk);
    for (int i = 0; i < 4; i++) begin
      chk("rst/rdy", {31'd0, pready_a[i]}, 32'd0);
      chk("rst/err", {31'd0, pslverr_a[i]}, 32'd0);
      chk("rst/rd", prdata_a[i], IDLE);
    end
    cyc();
    rst = 1'b0;
    cyc();

    // Two wait states: full write then read back, idle data afterwards.
    xfer(1, 2, 32'h10, 1'b1, 32'hDEAD_BEEF, 4'b1111, 1'b0, IDLE, "t1_wr");
    xfer(1, 2, 32'h10, 1'b0, 32'h0, 4'b0000, 1'b0, 32'hDEAD_BEEF, "t1_rd");
    @(negedge pclk);
    chk("t1_after/rd", prdata_a[1], IDLE);
    chk("t1_after/rdy", {31'd0, pready_a[1]}, 32'd0);
    cyc();

    // Partial strobe touches only the low two lanes.
    xfer(1, 2, 32'h10, 1'b1, 32'h0000_1234, 4'b0011, 1'b0, IDLE, "t2_wr");
    xfer(1, 2, 32'h10, 1'b0, 32'h0, 4'b0000, 1'b0, 32'hDEAD_1234, "t2_rd");

    // Out of range, misaligned and high-alias addresses all error without writing.
    xfer(1, 2, 32'h400, 1'b1, 32'h1111_1111, 4'b1111, 1'b1, IDLE, "t3_wr400");
    xfer(1, 2, 32'h11, 1'b1, 32'h2222_2222, 4'b1111, 1'b1, IDLE, "t3_wr11");
    xfer(1, 2, 32'h0001_0010, 1'b1, 32'h3333_3333, 4'b1111, 1'b1, IDLE, "t3_wralias");
    xfer(1, 2, 32'h10, 1'b0, 32'h0, 4'b0000, 1'b0, 32'hDEAD_1234, "t3_rd10");
    xfer(1, 2, 32'h400, 1'b0, 32'h0, 4'b0000, 1'b1, IDLE, "t3_rd400");

    // Zero wait states, back to back with no idle cycles.
    xfer(0, 0, 32'h0, 1'b1, 32'h1111_1111, 4'b1111, 1'b0, IDLE, "t4_wr0");
    xfer(0, 0, 32'h4, 1'b1, 32'h2222_2222, 4'b1111, 1'b0, IDLE, "t4_wr4");
    xfer(0, 0, 32'h0, 1'b0, 32'h0, 4'b0000, 1'b0, 32'h1111_1111, "t4_rd0");
    xfer(0, 0, 32'h4, 1'b0, 32'h0, 4'b0000, 1'b0, 32'h2222_2222, "t4_rd4");
    cyc();

    // Abort after one ACCESS cycle leaves memory untouched.
    xfer(2, 3, 32'h20, 1'b1, 32'h5555_AAAA, 4'b1111, 1'b0, IDLE, "t5_pre");
    psel    = 4'b0100;
    penable = 1'b0;
    paddr   = 32'h20;
    pwrite  = 1'b1;
    pwdata  = 32'hCAFE_F00D;
    pstrb   = 4'b1111;
    cyc();
    penable = 1'b1;
    @(negedge pclk);
    chk("t5_abort/acc_rdy", {31'd0, pready_a[2]}, 32'd0);
    cyc();
    psel    = 4'b0000;
    penable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk);
      chk("t5_abort/rdy", {31'd0, pready_a[2]}, 32'd0);
      cyc();
    end
    xfer(2, 3, 32'h20, 1'b0, 32'h0, 4'b0000, 1'b0, 32'h5555_AAAA, "t5_rd");

    // Reset during a read wait.
    xfer(3, 4, 32'h30, 1'b1, 32'h0BAD_F00D, 4'b1111, 1'b0, IDLE, "t6_pre");
    psel    = 4'b1000;
    penable = 1'b0;
    paddr   = 32'h30;
    pwrite  = 1'b0;
    cyc();
    penable = 1'b1;
    cyc();
    cyc();
    cyc();
    rst = 1'b1;
    #1;
    chk("t6_rst/rdy", {31'd0, pready_a[3]}, 32'd0);
    chk("t6_rst/rd", prdata_a[3], IDLE);
    chk("t6_rst/err", {31'd0, pslverr_a[3]}, 32'd0);
    psel    = 4'b0000;
    penable = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    xfer(3, 4, 32'h30, 1'b0, 32'h0, 4'b0000, 1'b0, 32'h0BAD_F00D, "t6_rd");
    xfer(0, 0, 32'h4, 1'b0, 32'h0, 4'b0000, 1'b0, 32'h2222_2222, "t6_keep0");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
